manual_drive_fsm: RTL and testbench

- Registered successor to the combinational manual-drive controller for the smart car.
- Owns three things:
  - the power FSM: long-press power-on, power-off, stall, and a new idle auto-off;
  - the drive FSM (NSTART/START/MOVING) with its moving sub-state;
  - the turn-signal and status lights, plus a new saturating mileage counter.
- Sits between the debounced switch/button inputs and the LED/7-seg display logic.
- All timing is parametrised from one internal ms tick. No separate divider instance is needed.

---
 rtl/manual_drive_fsm.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_manual_drive_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/manual_drive_fsm.sv
// manual_drive_fsm: registered power/drive FSM with turn lights and a saturating mileage counter.
// Optional: define BLINK_EN to flash START/MOVING turn lights every BLINK_TICKS ticks.
module manual_drive_fsm #(
  parameter int unsigned CLK_PER_TICK   = 100000,
  parameter int unsigned PON_HOLD_TICKS = 1000,
  parameter int unsigned IDLE_OFF_TICKS = 10000,
  parameter int unsigned MILE_TICKS     = 1000,
  parameter int unsigned MILE_W         = 16,
  parameter int unsigned BLINK_TICKS    = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_on,
  input  logic              power_off,
  input  logic              clutch,
  input  logic              brake,
  input  logic              throttle,
  input  logic              rgs,
  input  logic              left,
  input  logic              right,
  output logic              power,
  output logic [1:0]        state,
  output logic [3:0]        moving_state,
  output logic              turn_left_light,
  output logic              turn_right_light,
  output logic              power_light,
  output logic [2:0]        state_light,
  output logic [3:0]        moving_light,
  output logic [MILE_W-1:0] mileage
);

  typedef enum logic [1:0] {
    StNstart = 2'b00,
    StStart  = 2'b01,
    StMoving = 2'b10
  } drive_st_e;

  localparam logic [3:0] MsNone  = 4'b0000;
  localparam logic [3:0] MsFwd   = 4'b0001;
  localparam logic [3:0] MsBack  = 4'b0010;
  localparam logic [3:0] MsRight = 4'b0100;
  localparam logic [3:0] MsLeft  = 4'b1000;

  localparam int unsigned TickW    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned HoldW    = $clog2(PON_HOLD_TICKS + 1);
  localparam int unsigned IdleW    = $clog2(IDLE_OFF_TICKS + 1);
  localparam int unsigned MileCntW = $clog2(MILE_TICKS + 1);

  localparam logic [TickW-1:0]    TickLast = TickW'(CLK_PER_TICK - 1);
  localparam logic [HoldW-1:0]    HoldLast = HoldW'(PON_HOLD_TICKS - 1);
  localparam logic [IdleW-1:0]    IdleLast = IdleW'(IDLE_OFF_TICKS - 1);
  localparam logic [MileCntW-1:0] MileLast = MileCntW'(MILE_TICKS - 1);

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                power_q, power_d;
  drive_st_e           state_q, state_d;
  logic [3:0]          moving_q, moving_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                hold_lock_q, hold_lock_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [MileCntW-1:0] mile_cnt_q, mile_cnt_d;
  logic [MILE_W-1:0]   mileage_q, mileage_d;
  logic                tl_q, tl_d, tr_q, tr_d;
  logic                idle_run, idle_hit, stall, power_down;
  logic                lights_on;

`ifdef BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_TICKS + 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_ph_q, blink_ph_d;
  logic [1:0]        lr_q;
  logic              blink_restart;
`endif

  assign tick       = (tick_cnt_q == TickLast);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // Power and drive FSM next state.
  always_comb begin
    power_d     = power_q;
    state_d     = state_q;
    hold_d      = hold_q;
    hold_lock_d = hold_lock_q;
    idle_d      = idle_q;
    idle_run    = 1'b0;
    idle_hit    = 1'b0;
    stall       = 1'b0;
    power_down  = 1'b0;

    if (!power_q) begin
      state_d = StNstart;
      if (!power_on) begin
        hold_d      = '0;
        hold_lock_d = 1'b0;
      end else if (power_off || hold_lock_q) begin
        // A new long press is only accepted after power_on has been released.
        hold_d      = '0;
        hold_lock_d = 1'b1;
      end else if (tick) begin
        if (hold_q == HoldLast) begin
          power_d = 1'b1;
          hold_d  = '0;
          idle_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    end else begin
      idle_run = (state_q == StNstart) && !throttle && !clutch && !brake;
      idle_hit = idle_run && tick && (idle_q == IdleLast);
      if (!idle_run) begin
        idle_d = '0;
      end else if (tick) begin
        idle_d = idle_q + 1'b1;
      end

      unique case (state_q)
        StNstart: begin
          if (brake) begin
            state_d = StNstart;
          end else if (throttle && !clutch) begin
            stall = 1'b1;
          end else if (throttle && clutch && !rgs) begin
            state_d = StStart;
          end
        end
        StStart: begin
          if (brake) begin
            state_d = StNstart;
          end else if (throttle && !clutch) begin
            state_d = StMoving;
          end
        end
        StMoving: begin
          if (rgs && !clutch) begin
            stall = 1'b1;
          end else if (brake) begin
            state_d = StNstart;
          end else if (!throttle) begin
            state_d = StStart;
          end
        end
        default: state_d = StNstart;
      endcase

      power_down = power_off || stall || idle_hit;
      if (power_down) begin
        power_d     = 1'b0;
        state_d     = StNstart;
        hold_d      = '0;
        hold_lock_d = 1'b1;
        idle_d      = '0;
      end
    end
  end

  // Mileage: mile_cnt keeps its partial count outside MOVING and across power cycles.
  always_comb begin
    mile_cnt_d = mile_cnt_q;
    mileage_d  = mileage_q;
    if (power_q && (state_q == StMoving) && tick) begin
      if (mile_cnt_q == MileLast) begin
        mile_cnt_d = '0;
        if (mileage_q != {MILE_W{1'b1}}) begin
          mileage_d = mileage_q + 1'b1;
        end
      end else begin
        mile_cnt_d = mile_cnt_q + 1'b1;
      end
    end
  end

`ifdef BLINK_EN
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_ph_d    = blink_ph_q;
    blink_restart = !(power_d && (state_d != StNstart)) || ({left, right} != lr_q);
    if (blink_restart) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end
  assign lights_on = blink_ph_d;
`else
  assign lights_on = 1'b1;
`endif

  // Registered outputs follow the next state so they line up with power/state.
  always_comb begin
    moving_d = MsNone;
    tl_d     = 1'b0;
    tr_d     = 1'b0;
    if (power_d) begin
      if (state_d == StMoving) begin
        if (rgs) begin
          moving_d = MsBack;
        end else if (left && !right) begin
          moving_d = MsLeft;
        end else if (right && !left) begin
          moving_d = MsRight;
        end else begin
          moving_d = MsFwd;
        end
      end
      if (state_d == StNstart) begin
        tl_d = 1'b1;
        tr_d = 1'b1;
      end else begin
        tl_d = left && lights_on;
        tr_d = right && lights_on;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      power_q     <= 1'b0;
      state_q     <= StNstart;
      moving_q    <= MsNone;
      hold_q      <= '0;
      hold_lock_q <= 1'b0;
      idle_q      <= '0;
      mile_cnt_q  <= '0;
      mileage_q   <= '0;
      tl_q        <= 1'b0;
      tr_q        <= 1'b0;
`ifdef BLINK_EN
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      lr_q        <= 2'b00;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      power_q     <= power_d;
      state_q     <= state_d;
      moving_q    <= moving_d;
      hold_q      <= hold_d;
      hold_lock_q <= hold_lock_d;
      idle_q      <= idle_d;
      mile_cnt_q  <= mile_cnt_d;
      mileage_q   <= mileage_d;
      tl_q        <= tl_d;
      tr_q        <= tr_d;
`ifdef BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      lr_q        <= {left, right};
`endif
    end
  end

  always_comb begin
    state_light = 3'b000;
    if (power_q) begin
      unique case (state_q)
        StNstart: state_light = 3'b001;
        StStart:  state_light = 3'b010;
        StMoving: state_light = 3'b100;
        default:  state_light = 3'b000;
      endcase
    end
  end

  assign power            = power_q;
  assign state            = state_q;
  assign moving_state     = moving_q;
  assign turn_left_light  = tl_q;
  assign turn_right_light = tr_q;
  assign power_light      = power_q;
  assign moving_light     = power_q ? moving_q : MsNone;
  assign mileage          = mileage_q;

endmodule

// File: tb/tb_manual_drive_fsm.sv
// Bench for manual_drive_fsm: directed literal checks plus randomized stimulus vs a behavioural model.
// A second instance with a 2-bit mileage exercises saturation.
module tb_manual_drive_fsm;

  localparam int CPT   = 4;
  localparam int PON   = 3;
  localparam int IDLE  = 5;
  localparam int MILE  = 2;
  localparam int BLINK = 2;

  logic clk = 1'b0;
  logic rst, power_on, power_off, clutch, brake, throttle, rgs, left, right;

  logic        power, turn_left_light, turn_right_light, power_light;
  logic [1:0]  state;
  logic [3:0]  moving_state, moving_light;
  logic [2:0]  state_light;
  logic [15:0] mileage;

  logic        power2, tl2, tr2, pl2;
  logic [1:0]  state2;
  logic [3:0]  ms2, ml2;
  logic [2:0]  sl2;
  logic [1:0]  mileage2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  manual_drive_fsm #(
    .CLK_PER_TICK(CPT), .PON_HOLD_TICKS(PON), .IDLE_OFF_TICKS(IDLE),
    .MILE_TICKS(MILE), .MILE_W(16), .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .power_on(power_on), .power_off(power_off), .clutch(clutch),
    .brake(brake), .throttle(throttle), .rgs(rgs), .left(left), .right(right),
    .power(power), .state(state), .moving_state(moving_state),
    .turn_left_light(turn_left_light), .turn_right_light(turn_right_light),
    .power_light(power_light), .state_light(state_light), .moving_light(moving_light),
    .mileage(mileage)
  );

  manual_drive_fsm #(
    .CLK_PER_TICK(CPT), .PON_HOLD_TICKS(PON), .IDLE_OFF_TICKS(IDLE),
    .MILE_TICKS(MILE), .MILE_W(2), .BLINK_TICKS(BLINK)
  ) dut_sat (
    .clk(clk), .rst(rst), .power_on(power_on), .power_off(power_off), .clutch(clutch),
    .brake(brake), .throttle(throttle), .rgs(rgs), .left(left), .right(right),
    .power(power2), .state(state2), .moving_state(ms2),
    .turn_left_light(tl2), .turn_right_light(tr2),
    .power_light(pl2), .state_light(sl2), .moving_light(ml2),
    .mileage(mileage2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: drive state 0=NSTART 1=START 2=MOVING, mileage as an unbounded unit count.
  bit         m_on = 0;
  int         m_st = 0, m_hold = 0, m_idle = 0, m_dist = 0, m_units = 0, m_bt = 0, k = 0;
  bit         m_relock = 0;
  logic [3:0] m_ms = 0;
  bit         m_tl = 0, m_tr = 0;
  bit   [1:0] m_prev_lr = 0;

  always @(posedge clk) begin : model_p
    bit tk, go_off, bl;
    bit [1:0] lr;
    int nst;
    if (rst) begin
      m_on = 0; m_st = 0; m_hold = 0; m_idle = 0; m_dist = 0; m_units = 0; m_bt = 0; k = 0;
      m_relock = 0; m_ms = 0; m_tl = 0; m_tr = 0; m_prev_lr = 0;
    end else begin
      tk = (k % CPT) == CPT - 1;
      k++;
      lr = {left, right};
      if (!m_on) begin
        if (!power_on) begin
          m_hold = 0; m_relock = 0;
        end else if (power_off || m_relock) begin
          m_hold = 0; m_relock = 1;
        end else if (tk) begin
          m_hold++;
          if (m_hold == PON) begin
            m_on = 1; m_hold = 0; m_st = 0; m_idle = 0;
          end
        end
      end else begin
        go_off = power_off;
        nst = m_st;
        if (m_st == 0 && !throttle && !clutch && !brake) begin
          if (tk) m_idle++;
          if (m_idle == IDLE) go_off = 1;
        end else m_idle = 0;
        if (m_st == 2 && tk) begin
          m_dist++;
          if (m_dist == MILE) begin m_dist = 0; m_units++; end
        end
        case (m_st)
          0: if (!brake) begin
               if (throttle && !clutch) go_off = 1;
               else if (throttle && clutch && !rgs) nst = 1;
             end
          1: if (brake) nst = 0; else if (throttle && !clutch) nst = 2;
          default: if (rgs && !clutch) go_off = 1; else if (brake) nst = 0;
                   else if (!throttle) nst = 1;
        endcase
        if (go_off) begin
          m_on = 0; nst = 0; m_hold = 0; m_relock = 1; m_idle = 0;
        end
        m_st = nst;
      end
`ifdef BLINK_EN
      if (!(m_on && m_st != 0) || lr != m_prev_lr) m_bt = 0;
      else if (tk) m_bt++;
      bl = ((m_bt / BLINK) % 2) == 0;
`else
      bl = 1'b1;
`endif
      m_prev_lr = lr;
      if (m_on && m_st == 2)
        m_ms = rgs ? 4'b0010 : (left && !right) ? 4'b1000 : (right && !left) ? 4'b0100 : 4'b0001;
      else m_ms = 4'b0000;
      if (!m_on) begin m_tl = 0; m_tr = 0; end
      else if (m_st == 0) begin m_tl = 1; m_tr = 1; end
      else begin m_tl = left && bl; m_tr = right && bl; end
    end
  end

  always @(posedge clk) begin : compare_p
    #1;
    chk("power", power, m_on);
    chk("state", state, m_st);
    chk("moving_state", moving_state, m_ms);
    chk("turn_left_light", turn_left_light, m_tl);
    chk("turn_right_light", turn_right_light, m_tr);
    chk("power_light", power_light, m_on);
    chk("state_light", state_light, m_on ? (1 << m_st) : 0);
    chk("moving_light", moving_light, m_on ? m_ms : 4'b0);
    chk("mileage", mileage, (m_units > 65535) ? 65535 : m_units);
    chk("mileage_sat", mileage2, (m_units > 3) ? 3 : m_units);
  end

  task automatic wait_power_up(input string name);
    int i = 0;
    while (!power && i < 64) begin
      @(negedge clk);
      i++;
    end
    chk(name, power, 1);
  endtask

  initial begin
    rst = 1; power_on = 0; power_off = 0; clutch = 0; brake = 0; throttle = 0; rgs = 0;
    left = 0; right = 0;
    repeat (3) @(negedge clk);
    chk("rst_power", power, 0);
    chk("rst_state_light", state_light, 0);
    chk("rst_mileage", mileage, 0);

    // Long press: ticks land on edges 3, 7, 11 after reset release.
    rst = 0; power_on = 1;
    repeat (11) @(negedge clk);
    chk("pon_early", power, 0);
    @(negedge clk);
    chk("pon_power", power, 1);
    chk("pon_state_light", state_light, 3'b001);
    chk("pon_nstart_lights", {turn_left_light, turn_right_light}, 2'b11);

    // Idle auto-off after 5 quiet ticks.
    power_on = 0;
    repeat (19) @(negedge clk);
    chk("idle_not_yet", power, 1);
    @(negedge clk);
    chk("idle_off", power, 0);
    chk("idle_off_lights", {turn_left_light, turn_right_light, state_light}, 0);

    // Release after 2 ticks restarts the hold count.
    @(negedge clk);
    power_on = 1;
    repeat (8) @(negedge clk);
    power_on = 0;
    @(negedge clk);
    chk("short_press", power, 0);
    power_on = 1;
    repeat (9) @(negedge clk);
    chk("repress_early", power, 0);
    @(negedge clk);
    chk("repress_power", power, 1);

    // Normal drive and mileage.
    throttle = 1; clutch = 1;
    @(negedge clk);
    chk("drive_start", state, 2'b01);
    clutch = 0;
    @(negedge clk);
    chk("drive_moving", state, 2'b10);
    chk("drive_fwd", moving_state, 4'b0001);
    left = 1;
    @(negedge clk);
    chk("drive_left", moving_state, 4'b1000);
    chk("drive_left_lights", {turn_left_light, turn_right_light}, 2'b10);
    repeat (39) @(negedge clk);
    chk("mileage_10_ticks", mileage, 5);
    chk("mileage_saturated", mileage2, 3);
    throttle = 0;
    @(negedge clk);
    chk("release_start", state, 2'b01);
    chk("release_ms", moving_state, 4'b0000);
    repeat (24) @(negedge clk);
    chk("start_hold_mileage", mileage, 5);

    // Reverse without clutch while moving stalls.
    throttle = 1; rgs = 1;
    @(negedge clk);
    chk("rgs_moving", {state, moving_state}, {2'b10, 4'b0010});
    @(negedge clk);
    chk("rgs_stall_power", power, 0);
    chk("rgs_stall_outs", {state, state_light, turn_left_light, turn_right_light, moving_light}, 0);

    // Throttle without clutch in NSTART stalls; held power_on must not re-power.
    power_on = 0; rgs = 0; throttle = 0; left = 0;
    @(negedge clk);
    power_on = 1;
    wait_power_up("stall_n_powerup");
    throttle = 1; clutch = 0;
    @(negedge clk);
    chk("nstart_stall", power, 0);
    repeat (20) @(negedge clk);
    chk("relock_hold", power, 0);

    // Reset overrides power_off and throttle in the same cycle.
    power_on = 0; throttle = 0;
    @(negedge clk);
    power_on = 1;
    wait_power_up("prec_powerup");
    throttle = 1; clutch = 1;
    @(negedge clk);
    rst = 1; power_off = 1;
    @(negedge clk);
    chk("prec_outs", {power, state, moving_state, turn_left_light, turn_right_light,
                      state_light, moving_light}, 0);
    chk("prec_mileage", mileage, 0);
    rst = 0; power_off = 0; throttle = 0; clutch = 0;

    for (int seg = 0; seg < 500; seg++) begin
      rst       = ($urandom_range(0, 149) == 0);
      power_on  = ($urandom_range(0, 9) < 8);
      power_off = ($urandom_range(0, 24) == 0);
      clutch    = $urandom_range(0, 1);
      brake     = ($urandom_range(0, 5) == 0);
      throttle  = ($urandom_range(0, 2) != 0);
      rgs       = ($urandom_range(0, 7) == 0);
      left      = $urandom_range(0, 1);
      right     = $urandom_range(0, 1);
      repeat ($urandom_range(1, 16)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
